// File: rtl/mac_pkg.sv
// mac_pkg: shared state encoding, accumulator range helpers and default widths for the MAC datapath
package mac_pkg;
  localparam int PROD_W_DEF = 8;
  localparam int LEN_DEF = 4;
  localparam int ACC_W_DEF = 10;
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  function automatic longint acc_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction
  function automatic longint acc_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction
endpackage

// File: rtl/sat_add.sv
// sat_add: signed accumulator plus sign-extended product, with overflow flag and clamp or wrap
module sat_add
  import mac_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter bit SATURATE = 1'b1
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [PROD_W-1:0] prod,
  output logic signed [ACC_W-1:0]  sum,
  output logic                     ovf
);
  localparam logic signed [ACC_W-1:0] MAX = ACC_W'(acc_max(ACC_W));
  localparam logic signed [ACC_W-1:0] MIN = ACC_W'(acc_min(ACC_W));
  logic signed [ACC_W:0] wide;
  // one guard bit: the top two bits disagree exactly when the sum leaves the ACC_W range
  always_comb begin
    wide = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - PROD_W){prod[PROD_W-1]}}, prod};
    ovf = wide[ACC_W] ^ wide[ACC_W-1];
    sum = (SATURATE && ovf) ? (wide[ACC_W] ? MIN : MAX) : wide[ACC_W-1:0];
  end
endmodule

// File: rtl/signed_product_accumulator.sv
// signed_product_accumulator: sums LEN signed products per frame and hands the result out on valid/ready
module signed_product_accumulator
  import mac_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int LEN = LEN_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter bit SATURATE = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic signed [PROD_W-1:0] in_prod,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [ACC_W-1:0]  out_acc,
  output logic                     out_ovf,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
);
  localparam int CW = $clog2(LEN + 1);
  state_t state;
  logic signed [ACC_W-1:0] acc, sum;
  logic [CW-1:0] cnt;
  logic ovf, add_ovf, accept, last;
  sat_add #(.PROD_W(PROD_W), .ACC_W(ACC_W), .SATURATE(SATURATE)) u_add (
    .acc(acc),
    .prod(in_prod),
    .sum(sum),
    .ovf(add_ovf)
  );
  assign in_ready = (state != DONE) & ~flush & rst_n;
  assign accept = in_valid & in_ready;
  assign last = cnt == CW'(LEN - 1);
  assign busy = state != IDLE;
  // frame FSM: flush or a consumed result returns to IDLE; the last accept loads the result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      out_acc <= '0;
      out_ovf <= 1'b0;
      out_valid <= 1'b0;
    end else if (flush || (state == DONE && out_ready)) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept) begin
      acc <= sum;
      cnt <= cnt + 1'b1;
      ovf <= ovf | add_ovf;
      state <= last ? DONE : ACC;
      if (last) begin
        out_acc <= sum;
        out_ovf <= ovf | add_ovf;
        out_valid <= 1'b1;
      end
    end
  end
endmodule
